// File: rtl/hdmi_fifo_pkg.sv
// Shared constants and helpers for the HDMI output sync FIFO.
// Defines default widths, the depth function and the occupancy width.
package hdmi_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 256;
    localparam int DEF_ADDR_WIDTH = 6;

    // Occupancy needs one bit more than the address to represent a full FIFO.
    localparam int OCC_W = DEF_ADDR_WIDTH + 1;

    function automatic int fifo_depth(input int aw);
        return 1 << aw;
    endfunction

    function automatic int occ_width(input int aw);
        return aw + 1;
    endfunction

endpackage

// File: rtl/hdmi_fifo_ram.sv
// Simple dual-port RAM for the HDMI FIFO: synchronous write and a registered read.
// It also holds the optional output register stage, which is enabled by OUT_REG.
// Ports: clk, rst, wr_en/wr_addr/wr_data, rd_en/rd_addr, rd_data.
module hdmi_fifo_ram
    import hdmi_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int OUT_REG    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] ram_q;
    logic                  ram_vld;

    // Storage is left unreset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_q   <= '0;
            ram_vld <= 1'b0;
        end else begin
            ram_vld <= rd_en;
            if (rd_en) begin
                ram_q <= mem[rd_addr];
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] out_q;

            // The output stage advances only when a fresh word was loaded.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_q <= '0;
                end else if (ram_vld) begin
                    out_q <= ram_q;
                end
            end

            assign rd_data = out_q;
        end else begin : g_no_out_reg
            logic unused_vld;
            assign unused_vld = ram_vld;
            assign rd_data    = ram_q;
        end
    endgenerate

endmodule

// File: rtl/hdmi_out_sync_fifo.sv
// Single-clock 256-bit FIFO between the DDR read path and the HDMI output.
// It holds the pointers, the occupancy count and the registered flags.
// Ports: clk, rst, wr_data/wr_en/full/almost_full, rd_en/rd_data/empty/almost_empty.
// Optional macro HDMI_FIFO_WATER_LEVEL_EN adds the wr_water_level and rd_water_level outputs.
module hdmi_out_sync_fifo
    import hdmi_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH       = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
    parameter int OUT_REG          = 1,
    parameter int ALMOST_FULL_NUM  = 48,
    parameter int ALMOST_EMPTY_NUM = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    output logic                  full,
    output logic                  almost_full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
`ifdef HDMI_FIFO_WATER_LEVEL_EN
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   wr_water_level,
    output logic [ADDR_WIDTH:0]   rd_water_level
`else
    output logic                  almost_empty
`endif
);

    localparam int PW = occ_width(ADDR_WIDTH);
    localparam int DEPTH = fifo_depth(ADDR_WIDTH);

    localparam logic [PW-1:0] ONE    = PW'(1);
    localparam logic [PW-1:0] FULL_L = PW'(DEPTH);
    localparam logic [PW-1:0] AF_L   = PW'(ALMOST_FULL_NUM);
    localparam logic [PW-1:0] AE_L   = PW'(ALMOST_EMPTY_NUM);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] occ;
    logic [PW-1:0] occ_next;
    logic          wr_acc;
    logic          rd_acc;

    // Acceptance uses the registered flags, so a write while full or a read
    // while empty is dropped even if the other side moves on the same edge.
    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    always_comb begin
        occ_next = occ;
        unique case ({wr_acc, rd_acc})
            2'b10:   occ_next = occ + ONE;
            2'b01:   occ_next = occ - ONE;
            default: occ_next = occ;
        endcase
    end

    // The flags come from the next-state occupancy, so they settle on the
    // same edge at which the count changes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            occ          <= '0;
            full         <= 1'b0;
            almost_full  <= 1'b0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + ONE;
            end
            occ          <= occ_next;
            full         <= (occ_next == FULL_L);
            almost_full  <= (occ_next >= AF_L);
            empty        <= (occ_next == '0);
            almost_empty <= (occ_next <= AE_L);
        end
    end

`ifdef HDMI_FIFO_WATER_LEVEL_EN
    assign wr_water_level = occ;
    assign rd_water_level = occ;
`endif

    hdmi_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .OUT_REG    (OUT_REG)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
        .wr_data (wr_data),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_hdmi_out_sync_fifo.sv
// Directed self-checking bench for hdmi_out_sync_fifo (OUT_REG=1, depth 64).
// It covers reset, fill, drain, simultaneous read/write, pointer wrap and mid-stream reset.
module tb_hdmi_out_sync_fifo;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] wr_data;
    logic         wr_en;
    logic         full;
    logic         almost_full;
    logic         rd_en;
    logic [255:0] rd_data;
    logic         empty;
    logic         almost_empty;
`ifdef HDMI_FIFO_WATER_LEVEL_EN
    logic [6:0]   wr_water_level;
    logic [6:0]   rd_water_level;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hdmi_out_sync_fifo dut (
        .clk            (clk),
        .rst            (rst),
        .wr_data        (wr_data),
        .wr_en          (wr_en),
        .full           (full),
        .almost_full    (almost_full),
        .rd_en          (rd_en),
        .rd_data        (rd_data),
        .empty          (empty),
`ifdef HDMI_FIFO_WATER_LEVEL_EN
        .almost_empty   (almost_empty),
        .wr_water_level (wr_water_level),
        .rd_water_level (rd_water_level)
`else
        .almost_empty   (almost_empty)
`endif
    );

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic flags(input string tag, input logic f, input logic af,
                         input logic e, input logic ae);
        chk({tag, "_full"}, full, f);
        chk({tag, "_afull"}, almost_full, af);
        chk({tag, "_empty"}, empty, e);
        chk({tag, "_aempty"}, almost_empty, ae);
    endtask

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = '0;

        // Reset
        #200;
        flags("rst", 1'b0, 1'b0, 1'b1, 1'b1);
        chk("rst_rd_data", rd_data, 256'd0);
        @(negedge clk);
        rst = 1'b0;

        // Fill 0..63
        for (int i = 0; i < 64; i++) begin
            wr_en   = 1'b1;
            wr_data = 256'(i);
            step();
            flags("fill", (i + 1) == 64, (i + 1) >= 48, 1'b0, (i + 1) <= 4);
        end
        wr_data = 256'd99;
        step();
        flags("fill_drop", 1'b1, 1'b1, 1'b0, 1'b0);
        wr_en = 1'b0;

        // Drain 64 words; the data lags its accepting edge by one step here
        for (int j = 0; j < 64; j++) begin
            rd_en = 1'b1;
            step();
            if (j > 0) chk("drain_data", rd_data, 256'(j - 1));
            flags("drain", 1'b0, (63 - j) >= 48, j == 63, (63 - j) <= 4);
        end
        step();
        chk("drain_last", rd_data, 256'd63);
        step();
        chk("drain_hold", rd_data, 256'd63);
        chk("drain_empty", empty, 1'b1);
        rd_en = 1'b0;

        // Simultaneous read/write with occupancy 10
        for (int i = 0; i < 10; i++) begin
            wr_en   = 1'b1;
            wr_data = 256'(100 + i);
            step();
        end
        for (int k = 0; k < 5; k++) begin
            wr_en   = 1'b1;
            rd_en   = 1'b1;
            wr_data = 256'(110 + k);
            step();
            if (k > 0) chk("sim_data", rd_data, 256'(100 + k - 1));
            flags("sim", 1'b0, 1'b0, 1'b0, 1'b0);
        end
        wr_en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("sim_drain", rd_data, 256'(104 + k));
            chk("sim_empty", empty, k == 9);
        end
        rd_en = 1'b0;
        step();
        chk("sim_last", rd_data, 256'd114);

        // Both asserted while full
        for (int i = 0; i < 64; i++) begin
            wr_en   = 1'b1;
            wr_data = 256'(200 + i);
            step();
        end
        chk("af_full", full, 1'b1);
        rd_en   = 1'b1;
        wr_data = 256'd999;
        step();
        flags("fullrw", 1'b0, 1'b1, 1'b0, 1'b0);
        wr_en = 1'b0;
        for (int k = 0; k < 63; k++) begin
            step();
            chk("fullrw_data", rd_data, 256'(200 + k));
            chk("fullrw_empty", empty, k == 62);
        end
        rd_en = 1'b0;
        step();
        chk("fullrw_last", rd_data, 256'd263);
        chk("fullrw_drop", empty, 1'b1);

        // Pointer wrap: 3 rounds of write-40/read-40
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 40; i++) begin
                wr_en   = 1'b1;
                wr_data = 256'(1000 + r * 40 + i);
                step();
            end
            wr_en = 1'b0;
            flags("wrap_wr", 1'b0, 1'b0, 1'b0, 1'b0);
            for (int k = 0; k < 40; k++) begin
                rd_en = 1'b1;
                step();
                if (k > 0) chk("wrap_data", rd_data, 256'(1000 + r * 40 + k - 1));
                chk("wrap_aempty", almost_empty, (39 - k) <= 4);
            end
            rd_en = 1'b0;
            step();
            chk("wrap_last", rd_data, 256'(1000 + r * 40 + 39));
            flags("wrap_rd", 1'b0, 1'b0, 1'b1, 1'b1);
        end

        // Reset with 20 entries stored
        for (int i = 0; i < 20; i++) begin
            wr_en   = 1'b1;
            wr_data = 256'(500 + i);
            step();
        end
        wr_en = 1'b0;
        chk("mid_pre_empty", empty, 1'b0);
        rst = 1'b1;
        #2;
        flags("mid_rst", 1'b0, 1'b0, 1'b1, 1'b1);
        chk("mid_rst_data", rd_data, 256'd0);
        rst = 1'b0;
        step();
        wr_en   = 1'b1;
        wr_data = 256'd7;
        step();
        wr_en = 1'b0;
        chk("mid_wr_empty", empty, 1'b0);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk("mid_lat", rd_data, 256'd0);
        chk("mid_rd_empty", empty, 1'b1);
        step();
        chk("mid_data", rd_data, 256'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
